// File: rtl/usb_fs_pkg.sv
// Shared definitions for the full-speed USB transmit path: PID codes,
// tx arbiter state encoding and default inter-packet gap.
package usb_fs_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // 2 bit times at 48 MHz
  localparam int IPG_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/usb_fs_req_slot.sv
// One requester's pending flag, PID latch and age counter; drops the
// request on timeout or host pre-emption.
import usb_fs_pkg::*;

module usb_fs_req_slot #(
  parameter int REQ_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pid_in,
  input  logic       grant,
  input  logic       flush,
  output logic       pending,
  output logic [3:0] pid,
  output logic       dropped
);

  localparam int AW = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;
  // The increment that would bring age to REQ_TIMEOUT-1 is the expiry, so the
  // drop pulse lands exactly REQ_TIMEOUT cycles after the strobe.
  localparam logic [AW-1:0] AGE_EXP = AW'(REQ_TIMEOUT - 2);
  localparam logic [AW-1:0] AGE_MAX = '1;

  logic [AW-1:0] age;
  logic          expire;

  assign expire = pending && !grant && (age == AGE_EXP);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      pid     <= '0;
      age     <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (start) begin
        pending <= 1'b1;
        pid     <= pid_in;
        age     <= '0;
      end else if (pending && grant) begin
        pending <= 1'b0;
      end else if (pending && (flush || expire)) begin
        pending <= 1'b0;
        dropped <= 1'b1;
      end else if (pending && age != AGE_MAX) begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// Arbitrates the single full-speed tx serializer between protocol engines,
// enforcing the inter-packet gap and steering payload/handshakes.
import usb_fs_pkg::*;

module usb_fs_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int IPG_CYCLES  = IPG_CYCLES_DEF,
  parameter int REQ_TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_pkt_start,
  input  logic [4*NUM_REQ-1:0] req_pid,
  input  logic [NUM_REQ-1:0]   req_data_avail,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_data_get,
  output logic [NUM_REQ-1:0]   req_pkt_end,
  output logic [NUM_REQ-1:0]   req_dropped,
  input  logic                 rx_pkt_start,
  output logic                 tx_pkt_start,
  output logic [3:0]           tx_pid,
  output logic                 tx_data_avail,
  output logic [7:0]           tx_data,
  input  logic                 tx_data_get,
  input  logic                 tx_pkt_end
);

  localparam int GW = $clog2(IPG_CYCLES + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  tx_state_e                 state, state_nxt;
  logic [IW-1:0]             gnt_idx, gnt_nxt;
  logic [GW-1:0]             gap_cnt;
  logic [NUM_REQ-1:0]        pending, grant_vec;
  logic [NUM_REQ-1:0][3:0]   pid_in, pid;
  logic [NUM_REQ-1:0][7:0]   data_in;
  logic                      flush, do_grant, pkt_done, busy;

  assign pid_in  = req_pid;
  assign data_in = req_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    usb_fs_req_slot #(.REQ_TIMEOUT(REQ_TIMEOUT)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .start   (req_pkt_start[i]),
      .pid_in  (pid_in[i]),
      .grant   (grant_vec[i]),
      .flush   (flush),
      .pending (pending[i]),
      .pid     (pid[i]),
      .dropped (req_dropped[i])
    );
  end

  // lowest pending index wins
  always_comb begin
    gnt_nxt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (pending[i]) gnt_nxt = IW'(i);
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    flush     = 1'b0;
    pkt_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_pkt_start) begin
          flush = 1'b1;
        end else if (|pending) begin
          do_grant  = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      // an end strobe coincident with our own start belongs to no packet of ours
      ST_BUSY: begin
        if (tx_pkt_end && !tx_pkt_start) begin
          pkt_done  = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        flush = rx_pkt_start;
        if (gap_cnt == GW'(IPG_CYCLES - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign grant_vec = do_grant ? (NUM_REQ'(1) << gnt_nxt) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      gnt_idx      <= '0;
      gap_cnt      <= '0;
      tx_pkt_start <= 1'b0;
      tx_pid       <= '0;
      req_pkt_end  <= '0;
    end else begin
      state        <= state_nxt;
      tx_pkt_start <= do_grant;
      req_pkt_end  <= '0;
      if (do_grant) begin
        gnt_idx <= gnt_nxt;
        tx_pid  <= pid[gnt_nxt];
      end
      if (pkt_done) begin
        req_pkt_end[gnt_idx] <= 1'b1;
        gap_cnt              <= '0;
      end else if (state == ST_GAP && gap_cnt != '1) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  assign busy          = (state == ST_BUSY);
  assign tx_data_avail = busy && req_data_avail[gnt_idx];
  assign tx_data       = busy ? data_in[gnt_idx] : '0;

  always_comb begin
    req_data_get = '0;
    if (busy) req_data_get[gnt_idx] = tx_data_get && req_data_avail[gnt_idx];
  end

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Directed bench for usb_fs_tx_arbiter: grant latency, priority, payload
// steering, timeout, host pre-emption and reset mid-packet.
module tb_usb_fs_tx_arbiter;
  import usb_fs_pkg::*;

  localparam int IPG = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_pkt_start, req_data_avail, req_data_get, req_pkt_end, req_dropped;
  logic [7:0]  req_pid;
  logic [15:0] req_data;
  logic        rx_pkt_start, tx_pkt_start, tx_data_avail, tx_data_get, tx_pkt_end;
  logic [3:0]  tx_pid;
  logic [7:0]  tx_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usb_fs_tx_arbiter #(.NUM_REQ(2), .IPG_CYCLES(IPG), .REQ_TIMEOUT(40)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_pkt_start  (req_pkt_start),
    .req_pid        (req_pid),
    .req_data_avail (req_data_avail),
    .req_data       (req_data),
    .req_data_get   (req_data_get),
    .req_pkt_end    (req_pkt_end),
    .req_dropped    (req_dropped),
    .rx_pkt_start   (rx_pkt_start),
    .tx_pkt_start   (tx_pkt_start),
    .tx_pid         (tx_pid),
    .tx_data_avail  (tx_data_avail),
    .tx_data        (tx_data),
    .tx_data_get    (tx_data_get),
    .tx_pkt_end     (tx_pkt_end)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input logic [3:0] p);
    req_pkt_start[i]   = 1'b1;
    req_pid[i*4 +: 4]  = p;
    step();
    req_pkt_start      = '0;
  endtask

  // pulse tx_pkt_end, then sit out the whole gap so the arbiter is back in IDLE
  task automatic end_pkt();
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    step(IPG);
  endtask

  logic [7:0] pay [4];
  logic       seen;
  int         idx, gets, drop_at, drops;

  initial begin
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1;
    req_pkt_start = '0; req_pid = '0; req_data_avail = '0; req_data = '0;
    rx_pkt_start = 1'b0; tx_data_get = 1'b0; tx_pkt_end = 1'b0;
    step(2);
    chk("rst_start", tx_pkt_start, 0);
    chk("rst_pid", tx_pid, 0);
    chk("rst_outs", {req_data_get, req_pkt_end, req_dropped, tx_data_avail, tx_data}, 0);
    chk("rst_state", dut.state, ST_IDLE);
    reset = 1'b0;
    step();

    // 1: single request, latency and gap
    strobe(1, 4'b1010);
    chk("t1_early", tx_pkt_start, 0);
    step();
    chk("t1_start", tx_pkt_start, 1);
    chk("t1_pid", tx_pid, 4'b1010);
    step();
    chk("t1_one_cycle", tx_pkt_start, 0);
    step(2);
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    chk("t1_pkt_end", req_pkt_end, 2'b10);
    strobe(1, PID_DATA1);
    seen = 1'b0;
    for (int k = 0; k < IPG; k++) begin
      seen |= tx_pkt_start;
      step();
    end
    chk("t1_ipg_quiet", seen, 0);
    chk("t1_restart", tx_pkt_start, 1);
    chk("t1_pid2", tx_pid, PID_DATA1);
    step();
    end_pkt();

    // 2: priority, req 0 first, req 1 after the gap
    req_pkt_start = 2'b11;
    req_pid = {PID_ACK, PID_NAK};
    step();
    req_pkt_start = '0;
    step();
    chk("t2_start0", tx_pkt_start, 1);
    chk("t2_pid0", tx_pid, PID_NAK);
    step();
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    chk("t2_end0", req_pkt_end, 2'b01);
    seen = 1'b0;
    for (int k = 0; k < IPG; k++) begin
      step();
      seen |= tx_pkt_start;
    end
    chk("t2_quiet", seen, 0);
    step();
    chk("t2_start1", tx_pkt_start, 1);
    chk("t2_pid1", tx_pid, PID_ACK);
    step();
    end_pkt();

    // 3: payload steering; end strobe coincident with start is ignored
    req_data_avail = 2'b10;
    req_data[15:8] = 8'hEE;
    strobe(0, PID_DATA0);
    step();
    chk("t3_start", tx_pkt_start, 1);
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    chk("t3_end_ignored", req_pkt_end, 0);
    idx = 0; gets = 0; seen = 1'b0;
    for (int k = 0; k < 16 && idx < 4; k++) begin
      req_data_avail[0] = 1'b1;
      req_data[7:0]     = pay[idx];
      tx_data_get       = k[0];
      #1;
      seen |= req_data_get[1];
      if (tx_data_get && tx_data_avail) begin
        chk("t3_byte", tx_data, pay[idx]);
        chk("t3_get", req_data_get, 2'b01);
        gets++;
        idx++;
      end
      step();
    end
    req_data_avail = '0;
    tx_data_get = 1'b0;
    #1;
    chk("t3_gets", gets, 4);
    chk("t3_other_get", seen, 0);
    chk("t3_avail_off", tx_data_avail, 0);
    step();
    end_pkt();

    // 4: req 1 times out while req 0 holds the bus
    strobe(0, PID_DATA1);
    step();
    chk("t4_start0", tx_pkt_start, 1);
    step();
    strobe(1, PID_STALL);
    drop_at = -1; drops = 0; seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (req_dropped[1]) begin
        drops++;
        if (drop_at < 0) drop_at = k;
      end
      seen |= tx_pkt_start | req_dropped[0];
      if (k < 60) step();
    end
    chk("t4_drop_cycle", drop_at, 40);
    chk("t4_drop_count", drops, 1);
    chk("t4_no_other", seen, 0);
    step();
    end_pkt();
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= tx_pkt_start;
      step();
    end
    chk("t4_never_sent", seen, 0);

    // 5: host pre-emption during GAP
    strobe(1, PID_NAK);
    step();
    chk("t5_start", tx_pkt_start, 1);
    step();
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    step();
    strobe(0, PID_ACK);
    step();
    rx_pkt_start = 1'b1;
    step();
    rx_pkt_start = 1'b0;
    chk("t5_dropped", req_dropped, 2'b01);
    step();
    chk("t5_drop_pulse", req_dropped, 0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      seen |= tx_pkt_start;
      step();
    end
    chk("t5_no_start", seen, 0);
    chk("t5_idle", dut.state, ST_IDLE);

    // same-cycle strobe beats rx_pkt_start
    req_pkt_start[1] = 1'b1;
    req_pid[7:4] = PID_STALL;
    rx_pkt_start = 1'b1;
    step();
    req_pkt_start = '0;
    rx_pkt_start = 1'b0;
    chk("t5b_no_drop", req_dropped, 0);
    step();
    chk("t5b_start", tx_pkt_start, 1);
    chk("t5b_pid", tx_pid, PID_STALL);
    step();
    end_pkt();

    // 6: reset mid-packet
    strobe(0, PID_DATA0);
    step();
    chk("t6_start", tx_pkt_start, 1);
    req_data_avail[0] = 1'b1;
    req_data[7:0] = 8'h5A;
    tx_data_get = 1'b1;
    #1;
    chk("t6_byte", tx_data, 8'h5A);
    step(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_outs", {req_data_get, req_pkt_end, req_dropped, tx_data_avail, tx_data}, 0);
    chk("t6_start_pid", {tx_pkt_start, tx_pid}, 0);
    chk("t6_state", dut.state, ST_IDLE);
    tx_data_get = 1'b0;
    req_data_avail = '0;
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    chk("t6_end_ignored", req_pkt_end, 0);
    chk("t6_still_idle", dut.state, ST_IDLE);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_fs_tx_arbiter.md
Name: usb_fs_tx_arbiter

Overview:
Shares the single full-speed USB transmit path between several protocol engines, for example the IN PE data/STALL/NAK packets and the OUT PE handshakes.
- Latches each engine's one-cycle packet-start strobe and enforces the inter-packet gap.
- Grants the tx path to one requester at a time and steers payload bytes and handshakes between that requester and the tx serializer.
- Drops stale responses: on timeout, or when the host starts a new packet first.

Parameters:
NUM_REQ, 2, number of requesting protocol engines; index 0 has highest priority.
IPG_CYCLES, 8, minimum idle clk cycles between tx_pkt_end and the next tx_pkt_start (2 bit times at 48 MHz).
REQ_TIMEOUT, 40, clk cycles a pending request may wait for grant before being dropped.

Ports:
clk  input  1  system clock (48 MHz).
reset  input  1  synchronous, active-high reset.
req_pkt_start  input  NUM_REQ  one-cycle strobe per requester: send a packet.
req_pid  input  4*NUM_REQ  PID per requester; sampled on that requester's req_pkt_start.
req_data_avail  input  NUM_REQ  requester has a payload byte ready.
req_data  input  8*NUM_REQ  payload byte per requester.
req_data_get  output  NUM_REQ  byte consumed; routed to the granted requester only.
req_pkt_end  output  NUM_REQ  one-cycle strobe: this requester's packet finished on the wire.
req_dropped  output  NUM_REQ  one-cycle strobe: pending request discarded without transmission.
rx_pkt_start  input  1  receiver detected the start of a host packet.
tx_pkt_start  output  1  one-cycle strobe to the serializer.
tx_pid  output  4  PID of the granted packet; held stable from tx_pkt_start to tx_pkt_end.
tx_data_avail  output  1  req_data_avail of the granted requester while in BUSY, else 0.
tx_data  output  8  req_data of the granted requester (combinational mux).
tx_data_get  input  1  serializer consumed tx_data.
tx_pkt_end  input  1  serializer finished the packet (EOP sent).

Behaviour:
- Reset values: all outputs 0, state IDLE, pending/age/gap counters 0, grant index 0. Reset mid-packet abandons the grant immediately; no req_pkt_end or req_dropped pulse is generated.
- Pending capture, per requester i:
  - req_pkt_start[i] in cycle t sets pending[i], latches pid[i] and clears age[i]; visible in t+1.
  - A new strobe while already pending overwrites pid[i] and restarts age[i]; no drop pulse.
- Ageing: age[i] increments each cycle pending[i] is set and i is not granted.
  - When age[i] reaches REQ_TIMEOUT-1, the next cycle clears pending[i] and pulses req_dropped[i].
- Host pre-emption: rx_pkt_start while in IDLE or GAP clears all pending bits and pulses req_dropped for each bit that was set.
  - Ignored in BUSY.
  - A req_pkt_start in the same cycle as rx_pkt_start wins: that requester stays pending.
- FSM states: IDLE, BUSY, GAP.
  - IDLE → BUSY: when any pending bit is set, the lowest index g is granted. Registered outputs: tx_pkt_start=1 for one cycle, tx_pid=pid[g]; pending[g] cleared. Best-case latency is req_pkt_start at t → tx_pkt_start at t+2.
  - BUSY: tx_data_avail/tx_data are muxed from requester g; req_data_get[g]=tx_data_get & tx_data_avail; every other req_data_get bit is 0.
  - BUSY → GAP: on tx_pkt_end. req_pkt_end[g] pulses in the next cycle; the gap counter loads 0.
  - A req_pkt_start from g during BUSY becomes a new pending request and is not merged into the current packet.
  - GAP: the counter increments each cycle; at IPG_CYCLES-1 → IDLE. Pending requests still age during GAP.
- Simultaneous events:
  - A timeout expiring in the same cycle the request is granted: the grant wins, no drop.
  - tx_pkt_end in the same cycle as tx_pkt_start is ignored.
- Widths: age counter clog2(REQ_TIMEOUT) bits; gap counter clog2(IPG_CYCLES+1) bits; both saturate and never wrap.

Decomposition:
- Shared package (usb_fs_pkg): PID constants (DATA0/1, ACK, NAK, STALL), the state encoding, and the default IPG_CYCLES.
- One natural sub-module, usb_fs_req_slot: the per-requester pending flag, PID latch and age counter with drop logic, instantiated NUM_REQ times by generate.

Test Plan:
1. Single request: req_pkt_start[1] with pid 4'b1010 at t → tx_pkt_start at t+2, tx_pid=1010; tx_pkt_end at t+5 → req_pkt_end[1] at t+6, no further tx_pkt_start before t+6+IPG_CYCLES.
2. Priority: both requesters strobe in the same cycle → req 0 granted first; req 1 gets tx_pkt_start exactly IPG_CYCLES+1 cycles after req_pkt_end[0].
3. Payload steering: req 0 sends 4 bytes 0x11,0x22,0x33,0x44 with tx_data_get every other cycle → bytes arrive in order, 4 req_data_get[0] pulses, req_data_get[1] stays 0.
4. Timeout: req 1 strobes while req 0 holds BUSY for 60 cycles → req_dropped[1] exactly REQ_TIMEOUT cycles after its strobe, req 1 never transmitted.
5. Host pre-emption: req 0 strobes during GAP, rx_pkt_start 2 cycles later → req_dropped[0] pulse, state returns to IDLE with no tx_pkt_start.
6. Reset mid-packet: reset asserted in BUSY after 2 bytes → next cycle all outputs 0, state IDLE, subsequent tx_pkt_end ignored.
